tempo_sequencer: RTL and testbench

Tempo controller and sequencer for the metronome datapath. It owns the BPM value, set from the 18 tempo switches and nudged by the tap keys. It computes the per-step period with an iterative divider and sequences the 14-step LED ping-pong sweep and the speaker click. It also drives BCD tempo digits for HEX2..HEX0 and sits between board I/O (SW, KEY, CLOCK50) and the LED, speaker and HEX decoders.

---
 rtl/metronome_pkg.sv | 25 ++
 rtl/period_divider.sv | 83 ++++++++
 rtl/tempo_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_tempo_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/metronome_pkg.sv
// Shared constants, types and helper functions for the metronome tempo datapath.
package metronome_pkg;

  localparam int STEPS      = 14;
  localparam int BEAT_STEPS = 7;
  localparam int BPM_W      = 8;
  localparam int PER_W      = 32;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_e;

  function automatic logic [BPM_W-1:0] sw_to_bpm(input logic [4:0] idx);
    return BPM_W'(60) + BPM_W'(idx) * BPM_W'(10);
  endfunction

  // Ping-pong sweep: positions climb 0..7 then fall back 6..1.
  function automatic logic [7:0] step_to_led(input logic [3:0] step);
    logic [3:0] pos;
    pos = (step < 4'd8) ? step : 4'd14 - step;
    return 8'd1 << pos;
  endfunction

endpackage

// File: rtl/period_divider.sv
// Iterative restoring divider, one quotient bit per clock; start while busy restarts it.
module period_divider
  import metronome_pkg::*;
#(
  parameter int W = PER_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  // state    | meaning
  // DIV_IDLE | result held in quo_q, waiting for start
  // DIV_RUN  | shifting out one quotient bit per cycle

  localparam int CW = $clog2(W + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          done_q, done_d;
  logic [W:0]    trial;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    done_d  = 1'b0;
    trial   = {rem_q[W-1:0], quo_q[W-1]};
    if (start) begin
      state_d = DIV_RUN;
      cnt_d   = CW'(W);
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
    end else if (state_q == DIV_RUN) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = trial - {1'b0, dvs_q};
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = DIV_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == DIV_RUN);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/tempo_sequencer.sv
// Metronome tempo control, step sequencer, click and BCD readout.
// Define ACCENT_EN to lengthen and flag the click on the first beat of each 4-beat bar.
module tempo_sequencer
  import metronome_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int MIN_BPM      = 40,
  parameter int MAX_BPM      = 240,
  parameter int DEFAULT_BPM  = 120,
  parameter int CLICK_CYCLES = 2500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [17:0]       tempo_sw,
  input  logic              tap_up_n,
  input  logic              tap_down_n,
  output logic [BPM_W-1:0]  bpm,
  output logic [7:0]        led,
  output logic              click,
  output logic              beat_tick,
  output logic [3:0]        bcd_hund,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones,
  output logic              div_busy,
  output logic              accent
);

  localparam longint           DIVIDEND_L = longint'(CLK_HZ) * 60;
  localparam logic [PER_W-1:0] DIVIDEND   = PER_W'(DIVIDEND_L);
  localparam logic [PER_W-1:0] RESET_STEP = PER_W'(DIVIDEND_L / (longint'(DEFAULT_BPM) * 7));
  localparam logic [PER_W-1:0] CLICK_LEN  = PER_W'(CLICK_CYCLES);
  localparam logic [11:0]      RESET_BCD  = {4'(DEFAULT_BPM / 100), 4'((DEFAULT_BPM / 10) % 10),
                                             4'(DEFAULT_BPM % 10)};

  logic [2:0]       up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;
  logic [5:0]       sw_sel_q, sw_sel_d;
  logic             sw_load_q, sw_load_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic             div_start_q, div_start_d;
  logic [PER_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [PER_W-1:0] step_len_q, step_len_d;
  logic             beat_tick_q, beat_tick_d;
  logic [PER_W-1:0] click_left_q, click_left_d;
  logic [11:0]      bcd_q, bcd_d;

  logic             enc_valid, up_edge, dn_edge, tc;
  logic [4:0]       enc_idx;
  logic [3:0]       step_next;
  logic [PER_W-1:0] next_len, click_base;
  logic             div_done;
  logic [PER_W-1:0] div_quot;

`ifdef ACCENT_EN
  localparam logic [PER_W-1:0] ACCENT_LEN = PER_W'(2 * longint'(CLICK_CYCLES));
  logic [1:0] beat_cnt_q, beat_cnt_d;
  logic       accent_q, accent_d;
`endif

  period_divider #(.W(PER_W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start_q),
    .dividend (DIVIDEND),
    .divisor  (PER_W'(bpm_q) * PER_W'(7)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    enc_valid = 1'b0;
    enc_idx   = '0;
    for (int i = 17; i >= 0; i--) begin
      if (tempo_sw[i]) begin
        enc_valid = 1'b1;
        enc_idx   = 5'(i);
      end
    end
  end

  assign up_edge   = up_sync_q[2] & ~up_sync_q[1];
  assign dn_edge   = dn_sync_q[2] & ~dn_sync_q[1];
  assign tc        = (cnt_q == step_len_q - PER_W'(1));
  assign step_next = (step_q == 4'(STEPS - 1)) ? 4'd0 : step_q + 4'd1;
  assign next_len  = pend_vld_q ? pend_q : step_len_q;

  always_comb begin
    up_sync_d   = {up_sync_q[1:0], tap_up_n};
    dn_sync_d   = {dn_sync_q[1:0], tap_down_n};
    sw_sel_d    = sw_sel_q;
    sw_load_d   = 1'b0;
    bpm_d       = bpm_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cnt_d       = cnt_q + PER_W'(1);
    step_d      = step_q;
    step_len_d  = step_len_q;
    beat_tick_d = 1'b0;
    click_left_d = (click_left_q != '0) ? click_left_q - PER_W'(1) : '0;
`ifdef ACCENT_EN
    beat_cnt_d  = beat_cnt_q + 2'(beat_tick_q);
    accent_d    = accent_q;
    click_base  = (beat_cnt_q == 2'd0) ? ACCENT_LEN : CLICK_LEN;
`else
    click_base  = CLICK_LEN;
`endif

    if ({enc_valid, enc_idx} != sw_sel_q) begin
      sw_sel_d  = {enc_valid, enc_idx};
      sw_load_d = enc_valid;
    end

    // A pending switch load swallows any key edge arriving in the same cycle.
    if (sw_load_q)
      bpm_d = sw_to_bpm(sw_sel_q[4:0]);
    else if (up_edge && !dn_edge && bpm_q < BPM_W'(MAX_BPM))
      bpm_d = bpm_q + 1'b1;
    else if (dn_edge && !up_edge && bpm_q > BPM_W'(MIN_BPM))
      bpm_d = bpm_q - 1'b1;
    div_start_d = (bpm_d != bpm_q);

    if (tc) begin
      cnt_d      = '0;
      step_d     = step_next;
      step_len_d = next_len;
      pend_vld_d = 1'b0;
      click_left_d = '0;
      if (step_next == 4'd0 || step_next == 4'(BEAT_STEPS)) begin
        beat_tick_d  = 1'b1;
        click_left_d = (click_base < next_len) ? click_base : next_len;
`ifdef ACCENT_EN
        accent_d     = (beat_cnt_q == 2'd0);
`endif
      end
    end
    if (div_done) begin
      pend_d     = div_quot;
      pend_vld_d = 1'b1;
    end
    if (div_start_q)
      pend_vld_d = 1'b0;

    bcd_d = {4'(bpm_q / 8'd100), 4'((bpm_q / 8'd10) % 8'd10), 4'(bpm_q % 8'd10)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      up_sync_q    <= 3'b111;
      dn_sync_q    <= 3'b111;
      sw_sel_q     <= '0;
      sw_load_q    <= 1'b0;
      bpm_q        <= BPM_W'(DEFAULT_BPM);
      div_start_q  <= 1'b0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      cnt_q        <= '0;
      step_q       <= '0;
      step_len_q   <= RESET_STEP;
      beat_tick_q  <= 1'b0;
      click_left_q <= '0;
      bcd_q        <= RESET_BCD;
    end else begin
      up_sync_q    <= up_sync_d;
      dn_sync_q    <= dn_sync_d;
      sw_sel_q     <= sw_sel_d;
      sw_load_q    <= sw_load_d;
      bpm_q        <= bpm_d;
      div_start_q  <= div_start_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      step_len_q   <= step_len_d;
      beat_tick_q  <= beat_tick_d;
      click_left_q <= click_left_d;
      bcd_q        <= bcd_d;
    end
  end

`ifdef ACCENT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt_q <= '0;
      accent_q   <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      accent_q   <= accent_d;
    end
  end
  assign accent = accent_q & click;
`else
  assign accent = 1'b0;
`endif

  assign bpm       = bpm_q;
  assign led       = step_to_led(step_q);
  assign click     = (click_left_q != '0);
  assign beat_tick = beat_tick_q;
  assign bcd_hund  = bcd_q[11:8];
  assign bcd_tens  = bcd_q[7:4];
  assign bcd_ones  = bcd_q[3:0];

endmodule

// File: tb/tb_tempo_sequencer.sv
// Directed bench for tempo_sequencer at CLK_HZ=700, CLICK_CYCLES=5 (50-cycle steps at 120 BPM).
module tb_tempo_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] tempo_sw;
  logic        tap_up_n, tap_down_n;
  logic [7:0]  bpm, led;
  logic        click, beat_tick, div_busy, accent;
  logic [3:0]  bcd_hund, bcd_tens, bcd_ones;

  int checks = 0;
  int errors = 0;

  logic [7:0] led_exp [0:13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  always #5 clock = ~clock;

  tempo_sequencer #(
    .CLK_HZ(700), .MIN_BPM(40), .MAX_BPM(240), .DEFAULT_BPM(120), .CLICK_CYCLES(5)
  ) dut (
    .clock(clock), .reset(reset), .tempo_sw(tempo_sw), .tap_up_n(tap_up_n),
    .tap_down_n(tap_down_n), .bpm(bpm), .led(led), .click(click), .beat_tick(beat_tick),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .div_busy(div_busy),
    .accent(accent)
  );

  task automatic do_reset();
    reset = 1'b1; tempo_sw = '0; tap_up_n = 1'b1; tap_down_n = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press(input bit up, input bit dn);
    if (up) tap_up_n = 1'b0;
    if (dn) tap_down_n = 1'b0;
    repeat (4) @(negedge clock);
    tap_up_n = 1'b1; tap_down_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    int first_tick = 0, first_chg = 0, click_cnt = 0;
    do_reset();
    checks++;
    if (bpm !== 8'd120 || led !== 8'h01 || click !== 1'b0 || beat_tick !== 1'b0 ||
        div_busy !== 1'b0 || accent !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bpm=%0d led=%h click=%b tick=%b busy=%b accent=%b, want 120 01 0 0 0 0",
               bpm, led, click, beat_tick, div_busy, accent);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h120) begin
      errors++;
      $display("FAIL reset_bcd: got %h%h%h want 120", bcd_hund, bcd_tens, bcd_ones);
    end
    for (int n = 1; n <= 360; n++) begin
      @(posedge clock); #1;
      if (beat_tick && first_tick == 0) first_tick = n;
      if (led !== 8'h01 && first_chg == 0) first_chg = n;
      if (click) click_cnt++;
      if (n == 350) begin
        checks++;
        if (led !== 8'h80) begin
          errors++;
          $display("FAIL step7_led: got %h want 80", led);
        end
      end
    end
    checks++;
    if (first_chg != 50) begin
      errors++;
      $display("FAIL reset_step_len: first step ended at cycle %0d want 50", first_chg);
    end
    checks++;
    if (first_tick != 350) begin
      errors++;
      $display("FAIL first_beat_tick: at cycle %0d want 350", first_tick);
    end
    checks++;
    if (click_cnt != 5) begin
      errors++;
      $display("FAIL click_len: high %0d cycles want 5", click_cnt);
    end
  endtask

  task automatic test_switch();
    int busy_cnt = 0, chg1 = 0, chg2 = 0;
    logic [7:0] bpm_n1, bpm_n2, prev_led;
    logic [11:0] bcd_n2, bcd_n3;
    do_reset();
    tempo_sw = 18'h00001;
    prev_led = led;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (n == 1) bpm_n1 = bpm;
      if (n == 2) begin bpm_n2 = bpm; bcd_n2 = {bcd_hund, bcd_tens, bcd_ones}; end
      if (n == 3) bcd_n3 = {bcd_hund, bcd_tens, bcd_ones};
      if (div_busy) busy_cnt++;
      if (led !== prev_led) begin
        if (chg1 == 0) chg1 = n;
        else if (chg2 == 0) chg2 = n;
      end
      prev_led = led;
    end
    checks++;
    if (bpm_n1 !== 8'd120 || bpm_n2 !== 8'd60) begin
      errors++;
      $display("FAIL switch_load: bpm %0d then %0d want 120 then 60", bpm_n1, bpm_n2);
    end
    checks++;
    if (bcd_n2 !== 12'h120 || bcd_n3 !== 12'h060) begin
      errors++;
      $display("FAIL bcd_latency: %h then %h want 120 then 060", bcd_n2, bcd_n3);
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL div_busy_len: %0d cycles want 32", busy_cnt);
    end
    checks++;
    if (chg1 != 50 || chg2 != 150) begin
      errors++;
      $display("FAIL period_apply: boundaries at %0d,%0d want 50,150", chg1, chg2);
    end
  endtask

  task automatic test_tap();
    do_reset();
    repeat (3) press(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (bpm !== 8'd123 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h123) begin
      errors++;
      $display("FAIL tap_up3: bpm=%0d bcd=%h%h%h want 123", bpm, bcd_hund, bcd_tens, bcd_ones);
    end
    tempo_sw = 18'h20000;
    repeat (3) @(negedge clock);
    checks++;
    if (bpm !== 8'd230) begin
      errors++;
      $display("FAIL switch17: bpm=%0d want 230", bpm);
    end
    repeat (200) press(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (bpm !== 8'd240 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h240) begin
      errors++;
      $display("FAIL sat_max: bpm=%0d bcd=%h%h%h want 240", bpm, bcd_hund, bcd_tens, bcd_ones);
    end
    tempo_sw = 18'h00001;
    repeat (3) @(negedge clock);
    repeat (25) press(1'b0, 1'b1);
    checks++;
    if (bpm !== 8'd40) begin
      errors++;
      $display("FAIL sat_min: bpm=%0d want 40", bpm);
    end
  endtask

  task automatic test_collisions();
    do_reset();
    press(1'b1, 1'b1);
    checks++;
    if (bpm !== 8'd120) begin
      errors++;
      $display("FAIL both_keys: bpm=%0d want 120", bpm);
    end
    tap_up_n = 1'b0;
    @(negedge clock);
    tempo_sw = 18'h00006;
    repeat (4) @(negedge clock);
    tap_up_n = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (bpm !== 8'd70) begin
      errors++;
      $display("FAIL switch_over_key: bpm=%0d want 70", bpm);
    end
  endtask

  task automatic test_sweep();
    int ticks = 0;
    do_reset();
    for (int n = 1; n <= 700; n++) begin
      @(posedge clock); #1;
      if (beat_tick) ticks++;
      if (n % 50 == 0) begin
        checks++;
        if (led !== led_exp[(n / 50) % 14]) begin
          errors++;
          $display("FAIL sweep_led: cycle %0d got %h want %h", n, led, led_exp[(n / 50) % 14]);
        end
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL sweep_ticks: %0d want 2", ticks);
    end
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    do_reset();
    repeat (455) @(posedge clock);
    @(negedge clock);
    tap_up_n = 1'b0;
    while (!div_busy && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (!div_busy || led !== 8'h20 || bpm !== 8'd121) begin
      errors++;
      $display("FAIL mid_setup: busy=%b led=%h bpm=%0d want 1 20 121", div_busy, led, bpm);
    end
    tap_up_n = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (led !== 8'h01 || div_busy !== 1'b0 || bpm !== 8'd120 || click !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: led=%h busy=%b bpm=%0d click=%b want 01 0 120 0",
               led, div_busy, bpm, click);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_tap();
    test_collisions();
    test_sweep();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
